// File: rtl/rr_grant_pkg.sv
// Shared types and sizes for the round-robin grant scheduler.
package rr_grant_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} sched_state_t;
  localparam int NREQ   = 8;
  localparam int NSTEPS = 16;
endpackage

// File: rtl/rr_grant_sched_pick.sv
// Rotating priority encoder: first set request at or above ptr, wrapping 7->0.
module rr_pick
  import rr_grant_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic            any,
  output logic [2:0]      idx
);

  always_comb begin
    logic [2:0] cand;
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    // Walk from the farthest offset down so the nearest hit to ptr wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_grant_sched.sv
// Grants one of eight requesters for a fixed hold window, then enforces a dead gap.
//   state | meaning
//   IDLE  | waiting for any request; grants on the first cycle one is seen
//   GRANT | requester grant_idx holds the indicator; level counts down the window
//   GAP   | dead time after a grant; requests ignored
module rr_grant_sched
  import rr_grant_pkg::*;
#(
  parameter int TICKS_PER_STEP = 6,
  parameter int GAP_TICKS      = 10
) (
  input  logic              hz100,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  output logic              grant_valid,
  output logic [2:0]        grant_idx,
  output logic [NSTEPS-1:0] level,
  output logic              done,
  output logic              expired
);

  localparam int TW = $clog2(TICKS_PER_STEP + 1);
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_STEP - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);

  sched_state_t      state_q;
  logic [2:0]        ptr_q;
  logic [TW-1:0]     tick_q;
  logic [GW-1:0]     gap_q;
  logic [4:0]        steps_q;
  logic              grant_valid_q;
  logic [2:0]        grant_idx_q;
  logic [NSTEPS-1:0] level_q;
  logic              done_q;
  logic              expired_q;

  logic              pick_any;
  logic [2:0]        pick_idx;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Timers are down-counters: tick_q and gap_q reload with their last value and end at zero.
  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      tick_q        <= '0;
      gap_q         <= '0;
      steps_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      level_q       <= '0;
      done_q        <= 1'b0;
      expired_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q       <= GRANT;
            grant_valid_q <= 1'b1;
            grant_idx_q   <= pick_idx;
            ptr_q         <= pick_idx + 3'd1;
            steps_q       <= 5'(NSTEPS);
            tick_q        <= TICK_LAST;
            level_q       <= NSTEPS'(1) << (NSTEPS - 1);
          end
        end
        GRANT: begin
          // Release is checked first so it wins over expiry on the final tick.
          if (!req[grant_idx_q]) begin
            state_q       <= GAP;
            gap_q         <= GAP_LAST;
            grant_valid_q <= 1'b0;
            level_q       <= '0;
            done_q        <= 1'b1;
            expired_q     <= 1'b0;
          end else if (tick_q == '0) begin
            if (steps_q == 5'd1) begin
              state_q       <= GAP;
              gap_q         <= GAP_LAST;
              grant_valid_q <= 1'b0;
              level_q       <= '0;
              done_q        <= 1'b1;
              expired_q     <= 1'b1;
            end else begin
              steps_q <= steps_q - 5'd1;
              tick_q  <= TICK_LAST;
              level_q <= level_q >> 1;
            end
          end else begin
            tick_q <= tick_q - 1'b1;
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign level       = level_q;
  assign done        = done_q;
  assign expired     = expired_q;

endmodule

// File: tb/tb_rr_grant_sched.sv
// Directed bench for rr_grant_sched with TICKS_PER_STEP=2, GAP_TICKS=3.
module tb_rr_grant_sched;

  logic        hz100;
  logic        reset;
  logic [7:0]  req;
  logic        grant_valid;
  logic [2:0]  grant_idx;
  logic [15:0] level;
  logic        done;
  logic        expired;

  int n_checks;
  int n_errors;
  int lowc;

  rr_grant_sched #(.TICKS_PER_STEP(2), .GAP_TICKS(3)) dut (
    .hz100       (hz100),
    .reset       (reset),
    .req         (req),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .level       (level),
    .done        (done),
    .expired     (expired)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  task automatic do_reset();
    req   = 8'h00;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Waits for the next rising grant_valid; low_cycles counts sampled cycles with it low.
  task automatic next_grant(output int low_cycles);
    int n;
    n = 0;
    low_cycles = 0;
    while (grant_valid && n < 300) begin tick(); n++; end
    while (!grant_valid && n < 300) begin tick(); n++; low_cycles++; end
    check("grant_arrives", grant_valid, 1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    req   = 8'h00;
    reset = 1'b1;
    tick();
    tick();
    check("rst_valid", grant_valid, 0);
    check("rst_idx", grant_idx, 0);
    check("rst_level", level, 0);
    check("rst_done", done, 0);
    check("rst_expired", expired, 0);
    reset = 1'b0;
    tick();
    check("idle_no_req", grant_valid, 0);

    // Basic grant: full 32-cycle window then gap and re-grant
    req = 8'h04;
    tick();
    check("basic_idx", grant_idx, 2);
    for (int c = 0; c < 32; c++) begin
      logic [15:0] exp_lv;
      exp_lv = 16'h8000 >> (c / 2);
      check("basic_valid", grant_valid, 1);
      check("basic_level", level, exp_lv);
      check("basic_nodone", done, 0);
      tick();
    end
    check("basic_done", done, 1);
    check("basic_expired", expired, 1);
    check("basic_idx_hold", grant_idx, 2);
    for (int k = 0; k < 4; k++) begin
      check("basic_gap_valid", grant_valid, 0);
      check("basic_gap_level", level, 0);
      if (k > 0) check("basic_done_pulse", done, 0);
      tick();
    end
    check("basic_regrant", grant_valid, 1);
    check("basic_regrant_idx", grant_idx, 2);

    // Round-robin order with all requesting, including the 7->0 wrap
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      next_grant(lowc);
      check("rr_idx", grant_idx, (g % 8));
      if (g > 0) check("rr_spacing", lowc, 4);
    end

    // Rotating priority with two requesters
    do_reset();
    req = 8'h80;
    next_grant(lowc);
    check("rot_first7", grant_idx, 7);
    req = 8'h81;
    next_grant(lowc);
    check("rot_after7", grant_idx, 0);
    next_grant(lowc);
    check("rot_after0", grant_idx, 7);

    // Early release of requester 5 on its 4th grant cycle
    req = 8'hA0;
    next_grant(lowc);
    check("rel_idx", grant_idx, 5);
    check("rel_prev_expired", expired, 1);
    tick();
    tick();
    tick();
    check("rel_cycle4_valid", grant_valid, 1);
    check("rel_cycle4_level", level, 16'h4000);
    req = 8'h00;
    tick();
    check("rel_valid", grant_valid, 0);
    check("rel_done", done, 1);
    check("rel_expired", expired, 0);
    check("rel_level", level, 0);
    req = 8'h20;
    tick();
    check("rel_gap1_valid", grant_valid, 0);
    check("rel_gap1_done", done, 0);
    tick();
    check("rel_gap2_valid", grant_valid, 0);
    tick();
    check("rel_idle_valid", grant_valid, 0);
    tick();
    check("rel_regrant", grant_valid, 1);
    check("rel_regrant_idx", grant_idx, 5);

    // Natural expiry, then release colliding with the final terminal tick
    repeat (31) tick();
    check("col_last_level", level, 16'h0001);
    check("col_last_valid", grant_valid, 1);
    tick();
    check("col_exp_done", done, 1);
    check("col_exp_expired", expired, 1);
    next_grant(lowc);
    check("col_spacing", lowc, 4);
    repeat (31) tick();
    check("col_final_level", level, 16'h0001);
    req = 8'h00;
    tick();
    check("col_done", done, 1);
    check("col_expired", expired, 0);
    check("col_valid", grant_valid, 0);

    // Reset during the 10th grant cycle
    req = 8'h20;
    next_grant(lowc);
    repeat (9) tick();
    check("mid_valid", grant_valid, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", grant_valid, 0);
    check("mid_rst_idx", grant_idx, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_expired", expired, 0);
    tick();
    check("mid_rst_done2", done, 0);
    reset = 1'b0;
    req   = 8'h01;
    tick();
    check("post_rst_valid", grant_valid, 1);
    check("post_rst_idx", grant_idx, 0);
    check("post_rst_level", level, 16'h8000);
    check("post_rst_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
